apb_burst_sequencer: RTL
========================

Name: apb_burst_sequencer

Overview:
Sequences one accepted AXI burst command into a series of single-beat APB transfers. The block sits between the AXI-side channel buffers and the APB slaves of the bridge. It decodes the start address once per burst through the existing address decoder, then generates per-beat addresses for FIXED, INCR and WRAP bursts. It drives APB SETUP/ACCESS phases with wait-state handling and returns one response beat per AXI beat. Illegal or unmapped bursts complete with an error response and no APB activity.

Parameters:
SLAVE_CNT, `SLAVE_CNT from parameter_pkg (1..4), number of APB slaves / psel width
DW, 32, APB/AXI data width (fixed; only 4-byte transfers are legal)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high only in IDLE
cmd_addr  in  32  AXI start address
cmd_len  in  8  beats-1
cmd_size  in  3  AXI size
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
cmd_write  in  1  1=write burst
wdata_valid  in  1  write beat available
wdata_ready  out  1  one-cycle pulse consuming a write beat
wdata  in  32  write data
wstrb  in  4  write strobes
psel  out  SLAVE_CNT  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  32  APB address, bits[1:0]=0
pwdata  out  32  APB write data
pstrb  out  4  APB strobes (0 on reads)
prdata  in  32*SLAVE_CNT  per-slave read data, slave i at [32i+31:32i]
pready  in  SLAVE_CNT  per-slave ready
pslverr  in  SLAVE_CNT  per-slave error
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response beat accepted
rsp_data  out  32  read data (0 for writes/errors)
rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rsp_last  out  1  final beat of burst

Behaviour:
- Reset (async, any state): state=IDLE; cmd_ready=1. All other outputs are 0, including psel, penable, rsp_valid and wdata_ready. Internal address, beat counter and data registers are 0. Any in-flight APB transfer is abandoned.
- States: IDLE, DECODE, WDATA, SETUP, ACCESS, RESP, ERR_W, ERR_RESP.
- IDLE: cmd_valid&cmd_ready latches addr, len, size, burst and write. Beat counter is loaded with len. Next state is DECODE.
- DECODE (1 cycle): the decoder evaluates the latched start address, size and burst. Results are registered as the target index and error class. Error classes are evaluated in this order:
  - nonexist_transfer: SLVERR.
  - WRAP with len not in {1,3,7,15}: SLVERR.
  - dec_error, or true_psel all-zero (address-map hole): DECERR.
  - Otherwise: OKAY.
- DECODE exit: errors go to ERR_W (write) or ERR_RESP (read). Legal bursts go to WDATA (write) or SETUP (read).
- WDATA: waits for wdata_valid. On the valid cycle, wdata_ready=1 and pwdata/pstrb are captured. Next state is SETUP.
- SETUP (1 cycle): psel[target]=1, penable=0; paddr, pwrite and pstrb are stable. Next state is ACCESS.
- ACCESS: psel and penable are both 1. All APB outputs hold until pready[target]=1. On that cycle:
  - capture prdata[target] (reads only);
  - resp = pslverr[target] ? SLVERR : OKAY;
  - next cycle: psel=0, penable=0, state=RESP.
- RESP: rsp_valid=1 with rsp_last=(counter==0). Outputs are held until rsp_ready. On handshake:
  - if last: go to IDLE;
  - else: decrement counter, update address, go to WDATA (write) or SETUP (read).
- Error path, per beat: ERR_W consumes one wdata beat (same handshake as WDATA), then goes to ERR_RESP. ERR_RESP presents rsp_data=0 with the latched error resp. Exactly len+1 response beats are produced, and no psel is ever asserted.
- Next address, 32-bit arithmetic:
  - FIXED: unchanged.
  - INCR: addr+4, wraps at 2^32 with no error.
  - WRAP: mask=4*(len+1)-1; next=(addr&~mask)|((addr+4)&mask).
- The whole burst uses the target selected at DECODE. No re-decode occurs mid-burst.
- Latency for a read beat with zero wait states: SETUP→ACCESS→RESP, so rsp_valid asserts 3 cycles after DECODE.
- Back-to-back bursts: cmd_ready rises the cycle after the last response handshake.
- pready/pslverr from non-selected slaves are ignored.

Decomposition:
- parameter_pkg gains:
  - state enum seq_state_e;
  - resp constants RESP_OKAY/RESP_SLVERR/RESP_DECERR;
  - burst constants BURST_FIXED/INCR/WRAP.
- Existing slave address constants are reused.
- One sub-module is natural: an instance of decoder, driven by the latched command registers.
- Address generation stays inline as a function.

Test Plan:
- Read INCR at 0x0000_0004, len=3, size=2, slave0 pready=1 → paddr 0x04, 0x08, 0x0C, 0x10 on psel[0]; 4 OKAY beats, rsp_last on the 4th.
- Write WRAP at 0x0000_1038, len=3 (16-byte wrap) → paddr 0x1038, 0x103C, 0x1030, 0x1034 on psel[1]; pwrite=1; 4 wdata_ready pulses.
- Read with pready held low for 5 cycles and pslverr=1 at completion → psel/penable/paddr stable for 6 ACCESS cycles; rsp_resp=10.
- Write, size=3 or burst=11, len=1 → no psel, 2 wdata beats consumed, 2 SLVERR responses; address above the last slave end → 2 DECERR responses.
- areset asserted in ACCESS of beat 2 → psel, penable and rsp_valid are 0 immediately; cmd_ready=1 after release; the next burst runs normally.

Source files
------------

// File: rtl/apb_burst_sequencer_pkg.sv
// Shared states, response/burst codes and the APB slave address map
// used by the burst sequencer and its address decoder.
package apb_burst_sequencer_pkg;

  localparam int          DEF_SLAVE_CNT = 2;
  localparam logic [31:0] SLAVE_SPAN    = 32'h0000_1000;
  localparam logic [2:0]  SIZE_WORD     = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WDATA,
    SETUP,
    ACCESS,
    RESP,
    ERR_W,
    ERR_RESP
  } seq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // The map leaves 0x2000-0x2FFF unassigned so that wider configurations have a hole.
  function automatic logic [31:0] slaveBase(input int idx);
    case (idx)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_1000;
      2:       return 32'h0000_3000;
      default: return 32'h0000_4000;
    endcase
  endfunction

endpackage

// File: rtl/apb_burst_sequencer_decoder.sv
// Address decoder: maps a start address onto a one-hot slave select and
// flags transfers the bridge cannot perform.
module apb_burst_sequencer_decoder
  import apb_burst_sequencer_pkg::*;
#(
  parameter int SLAVE_CNT = DEF_SLAVE_CNT
) (
  input  logic [31:0]          addr_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [SLAVE_CNT-1:0] truePsel_o,
  output logic                 decError_o,
  output logic                 nonexistTransfer_o
);

  always_comb begin
    truePsel_o = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      truePsel_o[i] = (addr_i - slaveBase(i)) < SLAVE_SPAN;
    end
  end

  assign decError_o         = addr_i > (slaveBase(SLAVE_CNT - 1) + SLAVE_SPAN - 32'd1);
  assign nonexistTransfer_o = (size_i != SIZE_WORD) || (burst_i == 2'b11);

endmodule

// File: rtl/apb_burst_sequencer.sv
// Breaks one accepted AXI burst into single-beat APB transfers, one response
// beat per AXI beat; illegal or unmapped bursts answer with errors only.
module apb_burst_sequencer
  import apb_burst_sequencer_pkg::*;
#(
  parameter int SLAVE_CNT = DEF_SLAVE_CNT,
  parameter int DW        = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic                    cmd_write,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DW-1:0]           wdata,
  input  logic [DW/8-1:0]         wstrb,
  output logic [SLAVE_CNT-1:0]    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [31:0]             paddr,
  output logic [DW-1:0]           pwdata,
  output logic [DW/8-1:0]         pstrb,
  input  logic [DW*SLAVE_CNT-1:0] prdata,
  input  logic [SLAVE_CNT-1:0]    pready,
  input  logic [SLAVE_CNT-1:0]    pslverr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_last
);

  seq_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              write_q, write_d;
  logic [1:0]        target_q, target_d;
  logic [1:0]        errResp_q, errResp_d;
  logic [1:0]        resp_q, resp_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [DW/8-1:0]   pstrb_q, pstrb_d;

  logic [SLAVE_CNT-1:0] truePsel;
  logic                 decError;
  logic                 nonexistTransfer;
  logic [1:0]           targetIdx;
  logic [1:0]           decodeResp;
  logic                 wrapLenOk;
  logic                 selReady;
  logic                 selErr;
  logic [DW-1:0]        selRdata;
  logic                 apbActive;

  // Decoding always works on the latched command so the target is fixed for the whole burst.
  apb_burst_sequencer_decoder #(
    .SLAVE_CNT(SLAVE_CNT)
  ) u_decoder (
    .addr_i             (addr_q),
    .size_i             (size_q),
    .burst_i            (burst_q),
    .truePsel_o         (truePsel),
    .decError_o         (decError),
    .nonexistTransfer_o (nonexistTransfer)
  );

  function automatic logic [31:0] nextAddr(input logic [31:0] addr, input logic [1:0] burst,
                                           input logic [7:0] len);
    logic [31:0] mask;
    mask = ({22'd0, len, 2'b00} + 32'd4) - 32'd1;
    case (burst)
      BURST_FIXED: return addr;
      BURST_INCR:  return addr + 32'd4;
      BURST_WRAP:  return (addr & ~mask) | ((addr + 32'd4) & mask);
      default:     return addr;
    endcase
  endfunction

  assign wrapLenOk = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);

  always_comb begin
    if (nonexistTransfer || (burst_q == BURST_WRAP && !wrapLenOk)) decodeResp = RESP_SLVERR;
    else if (decError || truePsel == '0)                          decodeResp = RESP_DECERR;
    else                                                          decodeResp = RESP_OKAY;
  end

  always_comb begin
    targetIdx = '0;
    selReady  = 1'b0;
    selErr    = 1'b0;
    selRdata  = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      if (truePsel[i]) targetIdx = 2'(i);
      if (target_q == 2'(i)) begin
        selReady = pready[i];
        selErr   = pslverr[i];
        selRdata = prdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    write_d   = write_q;
    target_d  = target_q;
    errResp_d = errResp_q;
    resp_d    = resp_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    pstrb_d   = pstrb_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        cnt_d   = cmd_len;
        size_d  = cmd_size;
        burst_d = cmd_burst;
        write_d = cmd_write;
        state_d = DECODE;
      end
      DECODE: begin
        target_d  = targetIdx;
        errResp_d = decodeResp;
        if (decodeResp != RESP_OKAY) state_d = write_q ? ERR_W : ERR_RESP;
        else                         state_d = write_q ? WDATA : SETUP;
      end
      WDATA: if (wdata_valid) begin
        pwdata_d = wdata;
        pstrb_d  = wstrb;
        state_d  = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (selReady) begin
        if (!write_q) rdata_d = selRdata;
        resp_d  = selErr ? RESP_SLVERR : RESP_OKAY;
        state_d = RESP;
      end
      RESP, ERR_RESP: if (rsp_ready) begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - 8'd1;
          addr_d = nextAddr(addr_q, burst_q, len_q);
          if (state_q == RESP) state_d = write_q ? WDATA : SETUP;
          else                 state_d = write_q ? ERR_W : ERR_RESP;
        end
      end
      ERR_W: if (wdata_valid) state_d = ERR_RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      write_q   <= 1'b0;
      target_q  <= '0;
      errResp_q <= RESP_OKAY;
      resp_q    <= RESP_OKAY;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      pstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      write_q   <= write_d;
      target_q  <= target_d;
      errResp_q <= errResp_d;
      resp_q    <= resp_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      pstrb_q   <= pstrb_d;
    end
  end

  assign apbActive   = (state_q == SETUP) || (state_q == ACCESS);
  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = ((state_q == WDATA) || (state_q == ERR_W)) && wdata_valid;

  always_comb begin
    psel = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      psel[i] = apbActive && (target_q == 2'(i));
    end
  end

  assign penable   = (state_q == ACCESS);
  assign pwrite    = apbActive && write_q;
  assign paddr     = {addr_q[31:2], 2'b00};
  assign pwdata    = pwdata_q;
  assign pstrb     = write_q ? pstrb_q : '0;
  assign rsp_valid = (state_q == RESP) || (state_q == ERR_RESP);
  assign rsp_data  = (state_q == RESP && !write_q) ? rdata_q : '0;
  assign rsp_resp  = (state_q == RESP) ? resp_q : ((state_q == ERR_RESP) ? errResp_q : RESP_OKAY);
  assign rsp_last  = rsp_valid && (cnt_q == 8'd0);

endmodule
